// File: rtl/spi_slave_regif.sv
// SPI slave endpoint for the 24-bit ID/address/data frame. Oversamples the SPI
// pins on the system clock and turns each valid frame into a single register
// write or read on the local register bus.
`timescale 1ns / 1ps

module spi_slave_regif #(
  parameter logic [6:0]  SLAVE_ID    = 7'h32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       n_reset,
  input  logic       clock,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
  logic [SYNC_STAGES:0]   settle_q;
  logic                   ss_hist_q, sck_hist_q;
  logic                   ss_s, sck_s, mosi_s;
  logic                   sck_window, sck_rise, sck_fall, ss_fall;
  logic                   rise8, rise16, rise24;

  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_nxt;

  state_t     state_q, state_d;
  logic       rw_q, rw_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       frame_err_q, frame_err_d;

  // Pin synchronizers plus edge-history flops. The ss chain resets to its idle
  // (high) level; settle_q marks when the chain and history hold real pin
  // samples, so a frame already in progress at reset release is not joined.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ss_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_hist_q   <= 1'b1;
      sck_hist_q  <= 1'b0;
      settle_q    <= '0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_hist_q   <= ss_s;
      sck_hist_q  <= sck_s;
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // sck edges count while ss is low now or was low last cycle, so an sck rise
  // landing in the same cycle as the ss deassert is still processed.
  assign sck_window = ~(ss_s & ss_hist_q);
  assign sck_rise   = sck_s & ~sck_hist_q & sck_window;
  assign sck_fall   = ~sck_s & sck_hist_q & sck_window;
  assign ss_fall    = ~ss_s & ss_hist_q & settle_q[SYNC_STAGES];

  assign shift_nxt = {shift_q[6:0], mosi_s};
  assign rise8     = sck_rise && (bit_cnt_q == 5'd7);
  assign rise16    = sck_rise && (bit_cnt_q == 5'd15);
  assign rise24    = sck_rise && (bit_cnt_q == 5'd23);

  // Rise counter: clears while ss is high, saturates at 24.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (ss_s) begin
      bit_cnt_d = '0;
    end else if (sck_rise && (bit_cnt_q != 5'd24)) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
  end

  // Receive shift register and rise counter.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      if (sck_rise) shift_q <= shift_nxt;
    end
  end

  // Frame FSM next-state and register-bus/miso control.
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    tx_shift_d  = tx_shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    frame_err_d = 1'b0;

    // Read data arrives the cycle after the strobe; bit 7 goes out first.
    if (reg_re_q) begin
      tx_shift_d = reg_rdata;
      miso_d     = reg_rdata[7];
    end

    case (state_q)
      ST_IDLE: if (ss_fall) state_d = ST_ID;
      ST_ID: begin
        if (rise8) begin
          if (shift_nxt[7:1] == SLAVE_ID) begin
            state_d   = ST_ADDR;
            rw_d      = shift_nxt[0];
            miso_oe_d = shift_nxt[0];
          end else begin
            state_d = ST_IGNORE;
          end
        end
      end
      ST_ADDR: begin
        if (rise16) begin
          reg_addr_d = shift_nxt;
          reg_re_d   = rw_q;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        // Falls after rises 17..23 advance the transmit byte by one bit.
        if (rw_q && sck_fall && (bit_cnt_q >= 5'd17) && (bit_cnt_q <= 5'd23)) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          miso_d     = tx_shift_q[6];
        end
        if (rise24) begin
          if (!rw_q) begin
            reg_we_d    = 1'b1;
            reg_wdata_d = shift_nxt;
          end
          state_d = ST_IGNORE;
        end
      end
      ST_IGNORE: ;
      default: state_d = ST_IDLE;
    endcase

    // ss high ends the frame from any state; a matched frame cut short of its
    // 24th rise is flagged.
    if (ss_s) begin
      state_d     = ST_IDLE;
      miso_d      = 1'b0;
      miso_oe_d   = 1'b0;
      frame_err_d = (state_q inside {ST_ADDR, ST_DATA}) && (bit_cnt_q >= 5'd8) &&
                    !((state_q == ST_DATA) && rise24);
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      tx_shift_q  <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      tx_shift_q  <= tx_shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = miso_q & miso_oe_q;
  assign miso_oe   = miso_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = ~ss_s;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Testbench for spi_slave_regif: an SPI mode-0 master drives directed frames,
// expected register-bus events go into a scoreboard queue and are compared
// when the DUT strobes reg_we, reg_re or frame_err.
`timescale 1ns / 1ps

module tb_spi_slave_regif;

  localparam int HALF = 10;  // master sck half-period in system clocks
  localparam int GAP  = 16;  // ss high time between frames in system clocks

  typedef enum logic [1:0] {EV_WE, EV_RE, EV_FERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       n_reset, clock, ss, sck, mosi;
  logic       miso, miso_oe, reg_we, reg_re, busy, frame_err;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  ev_t        sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         oe_cycles   = 0;
  int         miso_cycles = 0;
  logic [7:0] rd_value = 8'h00;

  spi_slave_regif dut (
    .n_reset  (n_reset),
    .clock    (clock),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed unfinished expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic handle_event(input ev_kind_e k);
    ev_t e;
    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (k != EV_FERR) check("event_addr", 32'(reg_addr), 32'(e.addr));
      if (k == EV_WE)   check("event_wdata", 32'(reg_wdata), 32'(e.data));
    end
  endtask

  // Output monitor, sampled on the falling clock edge.
  always @(negedge clock) begin
    if (reg_we)    handle_event(EV_WE);
    if (reg_re)    handle_event(EV_RE);
    if (frame_err) handle_event(EV_FERR);
    if (miso_oe)   oe_cycles++;
    if (miso)      miso_cycles++;
  end

  // Register-bank model: the read value is valid only in the cycle after reg_re.
  initial begin
    reg_rdata = 8'h00;
    forever begin
      @(negedge clock);
      reg_rdata = reg_re ? rd_value : ~rd_value;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  // Drives nbits of the frame, leaving ss low and sck low at the end.
  task automatic spi_frame(input logic [7:0] id, input logic [7:0] addr, input logic [7:0] data,
                           input int nbits, output logic [7:0] rdata,
                           output logic oe_pre8, output logic oe_post8);
    logic [23:0] fr;
    fr       = {id, addr, data};
    rdata    = 8'h00;
    oe_pre8  = 1'b0;
    oe_post8 = 1'b0;
    @(negedge clock);
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = fr[23-i];
      clks(HALF);
      sck = 1'b1;
      if (i >= 16) rdata = {rdata[6:0], miso};
      if (i == 7) oe_pre8 = miso_oe;
      clks(HALF);
      if (i == 7) oe_post8 = miso_oe;
      sck = 1'b0;
    end
  endtask

  task automatic finish_frame(input string tag, input logic exp_oe);
    clks(HALF);
    check({tag, "_oe_before_ss"}, 32'(miso_oe), 32'(exp_oe));
    check({tag, "_busy_in_frame"}, 32'(busy), 32'd1);
    ss = 1'b1;
    clks(GAP);
    check({tag, "_oe_after_ss"}, 32'(miso_oe), 32'd0);
    check({tag, "_busy_after_ss"}, 32'(busy), 32'd0);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
    check({tag, "_reg_we"}, 32'(reg_we), 32'd0);
    check({tag, "_reg_re"}, 32'(reg_re), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    logic [7:0] rdata;
    logic       oe_pre8, oe_post8;
    logic [7:0] bad_ids[3];
    int         oe0, miso0;

    bad_ids = '{8'h66, 8'h77, 8'h11};
    n_reset = 1'b0;
    ss      = 1'b1;
    sck     = 1'b0;
    mosi    = 1'b0;
    clks(3);
    check_reset_values("por");
    n_reset = 1'b1;
    clks(5);

    // Write frame.
    push(EV_WE, 8'h12, 8'hA5);
    spi_frame(8'h64, 8'h12, 8'hA5, 24, rdata, oe_pre8, oe_post8);
    check("wr_oe_after_id", 32'(oe_post8), 32'd0);
    finish_frame("wr", 1'b0);

    // Read frame.
    rd_value = 8'h5A;
    push(EV_RE, 8'h34, 8'h00);
    spi_frame(8'h65, 8'h34, 8'h00, 24, rdata, oe_pre8, oe_post8);
    check("rd_oe_at_rise8", 32'(oe_pre8), 32'd0);
    check("rd_oe_after_rise8", 32'(oe_post8), 32'd1);
    check("rd_rdata", 32'(rdata), 32'h5A);
    finish_frame("rd", 1'b1);

    // Foreign IDs: nothing may happen on the bus or the miso pin.
    for (int k = 0; k < 3; k++) begin
      oe0   = oe_cycles;
      miso0 = miso_cycles;
      rd_value = 8'hFF;
      spi_frame(bad_ids[k], 8'h55, 8'hAA, 24, rdata, oe_pre8, oe_post8);
      finish_frame("badid", 1'b0);
      check("badid_oe_cycles", 32'(oe_cycles - oe0), 32'd0);
      check("badid_miso_cycles", 32'(miso_cycles - miso0), 32'd0);
    end

    // Write aborted after 4 data bits, then a normal write.
    push(EV_FERR, 8'h00, 8'h00);
    spi_frame(8'h64, 8'h20, 8'hF0, 20, rdata, oe_pre8, oe_post8);
    finish_frame("abort", 1'b0);
    push(EV_WE, 8'h21, 8'h3C);
    spi_frame(8'h64, 8'h21, 8'h3C, 24, rdata, oe_pre8, oe_post8);
    finish_frame("after_abort", 1'b0);

    // Reset asserted mid-read, then a clean read.
    rd_value = 8'h77;
    push(EV_RE, 8'h40, 8'h00);
    spi_frame(8'h65, 8'h40, 8'h00, 20, rdata, oe_pre8, oe_post8);
    check("midrd_oe_before_reset", 32'(miso_oe), 32'd1);
    n_reset = 1'b0;
    #1;
    check_reset_values("midrst");
    ss  = 1'b1;
    sck = 1'b0;
    clks(4);
    n_reset = 1'b1;
    clks(10);
    check("post_rst_addr", 32'(reg_addr), 32'd0);
    check("post_rst_sb", 32'(sb.size()), 32'd0);
    rd_value = 8'hC3;
    push(EV_RE, 8'h01, 8'h00);
    spi_frame(8'h65, 8'h01, 8'h00, 24, rdata, oe_pre8, oe_post8);
    check("post_rst_rdata", 32'(rdata), 32'hC3);
    finish_frame("post_rst_rd", 1'b1);

    // Back-to-back write then read of the same register.
    push(EV_WE, 8'h10, 8'hFF);
    spi_frame(8'h64, 8'h10, 8'hFF, 24, rdata, oe_pre8, oe_post8);
    finish_frame("b2b_wr", 1'b0);
    rd_value = 8'hFF;
    push(EV_RE, 8'h10, 8'h00);
    spi_frame(8'h65, 8'h10, 8'h00, 24, rdata, oe_pre8, oe_post8);
    check("b2b_rdata", 32'(rdata), 32'hFF);
    finish_frame("b2b_rd", 1'b1);

    clks(10);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
